// File: rtl/ram_dport_rmw.sv
// Data-port access controller for RAM port 2: loads, word stores, and sub-word stores via read-modify-write.
// Optional address range check enabled by defining DPORT_RANGE_CHK_EN.
module ram_dport_rmw #(
  parameter int DEPTH = 513,
  parameter int AW    = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [3:0]    cpu_be_i,
  input  logic [31:0]   cpu_addr_i,
  input  logic [31:0]   cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic [31:0]   cpu_rdata_o,
  output logic          cpu_busy_o,
  output logic          cpu_err_o,
  output logic          ram2_stb_o,
  output logic          ram2_we_o,
  output logic [AW-1:0] ram2_addr_o,
  output logic [31:0]   ram2_data_o,
  input  logic [31:0]   ram2_data_i
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

  state_t        state, state_nxt;
  logic          we_q;
  logic [3:0]    be_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   merged_q;
  logic [31:0]   rdata_q;
  logic          oor;
  logic          accept;

  assign accept = (state == IDLE) && cpu_req_i;

`ifdef DPORT_RANGE_CHK_EN
  logic err_q;
  assign oor = (cpu_addr_i[31:2] >= 30'(DEPTH));
`else
  assign oor = 1'b0;
`endif

  // Byte-offset bits never matter; upper bits only matter to the range check.
  logic unused_addr;
  assign unused_addr = ^{cpu_addr_i[1:0], cpu_addr_i[31:AW+2]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_req_i) begin
          if (oor)                   state_nxt = RESP;
          else if (!cpu_we_i)        state_nxt = RD;
          else if (cpu_be_i == 4'hF) state_nxt = WR;
          else if (cpu_be_i == 4'h0) state_nxt = RESP;
          else                       state_nxt = RD;
        end
      end
      RD:      state_nxt = RDW;
      RDW:     state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // merged_q starts as the store data; unselected lanes are overwritten from the RAM read.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      addr_q   <= '0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
    end else if (accept) begin
      we_q     <= cpu_we_i;
      be_q     <= cpu_be_i;
      addr_q   <= cpu_addr_i[AW+1:2];
      merged_q <= cpu_wdata_i;
      if (oor && !cpu_we_i) rdata_q <= 32'h0;
    end else if (state == RDW) begin
      if (we_q) begin
        for (int i = 0; i < 4; i++)
          if (!be_q[i]) merged_q[8*i +: 8] <= ram2_data_i[8*i +: 8];
      end else begin
        rdata_q <= ram2_data_i;
      end
    end
  end

`ifdef DPORT_RANGE_CHK_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  err_q <= 1'b0;
    else if (accept) err_q <= oor;
  end
  assign cpu_err_o = err_q && (state == RESP);
`else
  assign cpu_err_o = 1'b0;
`endif

  assign cpu_ack_o   = (state == RESP);
  assign cpu_busy_o  = (state != IDLE);
  assign cpu_rdata_o = rdata_q;
  assign ram2_stb_o  = (state == RD) || (state == WR);
  assign ram2_we_o   = (state == WR);
  assign ram2_addr_o = addr_q;
  assign ram2_data_o = merged_q;

endmodule

// File: tb/tb_ram_dport_rmw.sv
// Self-checking bench for ram_dport_rmw: vector table, corner sequences, and randomized traffic against a byte-lane memory model.
module tb_ram_dport_rmw;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [3:0]  cpu_be_i = 4'h0;
  logic [31:0] cpu_addr_i = 32'h0, cpu_wdata_i = 32'h0;
  logic        cpu_ack_o, cpu_busy_o, cpu_err_o, ram2_stb_o, ram2_we_o;
  logic [31:0] cpu_rdata_o, ram2_data_o, ram2_data_i;
  logic [15:0] ram2_addr_o;

  int errors = 0;
  int checks = 0;

  ram_dport_rmw #(.DEPTH(513), .AW(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_be_i(cpu_be_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o), .cpu_busy_o(cpu_busy_o),
    .cpu_err_o(cpu_err_o), .ram2_stb_o(ram2_stb_o), .ram2_we_o(ram2_we_o),
    .ram2_addr_o(ram2_addr_o), .ram2_data_o(ram2_data_o), .ram2_data_i(ram2_data_i)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous RAM attached to port 2: read data appears the cycle after the strobe.
  logic [31:0] ram [0:65535];
  logic [31:0] ram_q = 32'h0;
  assign ram2_data_i = ram_q;
  always @(posedge sys_clk)
    if (ram2_stb_o) begin
      if (ram2_we_o) ram[ram2_addr_o] <= ram2_data_o;
      else           ram_q <= ram[ram2_addr_o];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request; latencies counted in cycles after the acceptance edge (cycle 1 = first after it).
  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output int nstb, output int wcyc, output logic [31:0] wdat,
                        output logic [15:0] waddr, output logic [15:0] raddr, output logic err);
    @(negedge sys_clk);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_be_i = be; cpu_addr_i = addr; cpu_wdata_i = wdata;
    @(posedge sys_clk);
    #1 cpu_req_i = 1'b0;
    lat = -1; nstb = 0; wcyc = 0; wdat = 0; waddr = 0; raddr = 0; rdata = 0; err = 0;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      @(negedge sys_clk);
      if (ram2_stb_o) begin
        nstb++;
        if (ram2_we_o) begin wcyc = i; wdat = ram2_data_o; waddr = ram2_addr_o; end
        else raddr = ram2_addr_o;
      end
      if (cpu_ack_o) begin lat = i; rdata = cpu_rdata_o; err = cpu_err_o; end
    end
  endtask

  typedef struct {
    logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
    int lat; int nstb; int wcyc; logic [31:0] exp_w; logic [31:0] exp_r;
  } vec_t;

  vec_t vecs[10];
  logic [31:0] ref_mem [0:15];

  initial begin
    int lat, nstb, wcyc, acks, stbs, busys, last_ack, gaps_bad;
    logic [31:0] rdata, wdat, last_load;
    logic [15:0] waddr, raddr;
    logic err, have_load;

    for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    vecs[0] = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 2, 1, 1, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 4'h0, 32'h10, 32'h0,        3, 1, 0, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 4'h2, 32'h10, 32'h0000AA00, 4, 2, 3, 32'hDEADAAEF, 32'h0};
    vecs[3] = '{1'b0, 4'h0, 32'h13, 32'h0,        3, 1, 0, 32'h0, 32'hDEADAAEF};
    vecs[4] = '{1'b1, 4'h0, 32'h10, 32'h12345678, 1, 0, 0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 4'h0, 32'h10, 32'h0,        3, 1, 0, 32'h0, 32'hDEADAAEF};
    vecs[6] = '{1'b1, 4'h9, 32'h20, 32'h11223344, 4, 2, 3, 32'h11000044, 32'h0};
    vecs[7] = '{1'b0, 4'h0, 32'h20, 32'h0,        3, 1, 0, 32'h0, 32'h11000044};
    vecs[8] = '{1'b1, 4'hC, 32'h24, 32'hAABBCCDD, 4, 2, 3, 32'hAABB0000, 32'h0};
    vecs[9] = '{1'b0, 4'h0, 32'h24, 32'h0,        3, 1, 0, 32'h0, 32'hAABB0000};

    // Reset values
    #3;
    chk("rst_ctl", {31'h0, |{cpu_ack_o, cpu_busy_o, cpu_err_o, ram2_stb_o, ram2_we_o}}, 32'h0);
    chk("rst_addr", {16'h0, ram2_addr_o}, 32'h0);
    chk("rst_wdata", ram2_data_o, 32'h0);
    chk("rst_rdata", cpu_rdata_o, 32'h0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Reset asserted while the write strobe is up
    @(negedge sys_clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_be_i = 4'hF; cpu_addr_i = 32'h400; cpu_wdata_i = 32'hCAFEF00D;
    @(posedge sys_clk);
    #1 cpu_req_i = 1'b0;
    chk("wr_before_rst", {30'h0, ram2_stb_o, ram2_we_o}, 32'h3);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {27'h0, cpu_ack_o, cpu_busy_o, cpu_err_o, ram2_stb_o, ram2_we_o}, 32'h0);
    chk("midrst_addr", {16'h0, ram2_addr_o}, 32'h0);
    chk("midrst_data", ram2_data_o, 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    acks = 0; busys = 0;
    repeat (6) begin
      @(negedge sys_clk);
      acks += int'(cpu_ack_o); busys += int'(cpu_busy_o);
    end
    chk("midrst_no_ack", acks, 0);
    chk("midrst_busy", busys, 0);
    chk("midrst_no_write", ram[16'h100], 32'h0);

    // Table of directed transactions
    for (int v = 0; v < 10; v++) begin
      do_req(vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata,
             lat, rdata, nstb, wcyc, wdat, waddr, raddr, err);
      chk($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
      chk($sformatf("vec%0d_nstb", v), nstb, vecs[v].nstb);
      if (vecs[v].we) begin
        chk($sformatf("vec%0d_wcyc", v), wcyc, vecs[v].wcyc);
        if (vecs[v].wcyc != 0) begin
          chk($sformatf("vec%0d_wdat", v), wdat, vecs[v].exp_w);
          chk($sformatf("vec%0d_waddr", v), {16'h0, waddr}, vecs[v].addr >> 2);
        end
      end else begin
        chk($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_r);
        chk($sformatf("vec%0d_raddr", v), {16'h0, raddr}, vecs[v].addr >> 2);
      end
    end

    // Out-of-range word 513
    do_req(1'b0, 4'h0, 32'h804, 32'h0, lat, rdata, nstb, wcyc, wdat, waddr, raddr, err);
`ifdef DPORT_RANGE_CHK_EN
    chk("oor_lat", lat, 1);
    chk("oor_err", {31'h0, err}, 32'h1);
    chk("oor_rdata", rdata, 32'h0);
    chk("oor_nstb", nstb, 0);
`else
    chk("oor_lat", lat, 3);
    chk("oor_err", {31'h0, err}, 32'h0);
    chk("oor_raddr", {16'h0, raddr}, 32'h201);
    chk("oor_nstb", nstb, 1);
`endif

    // Request held high: loads recur every 4 cycles (3 busy + 1 idle)
    @(negedge sys_clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_be_i = 4'h0; cpu_addr_i = 32'h10;
    acks = 0; stbs = 0; busys = 0; last_ack = -1; gaps_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (cpu_ack_o) begin
        if (last_ack >= 0 && i - last_ack != 4) gaps_bad++;
        last_ack = i; acks++;
      end
      stbs += int'(ram2_stb_o); busys += int'(cpu_busy_o);
    end
    cpu_req_i = 1'b0;
    chk("held_acks", acks, 10);
    chk("held_stbs", stbs, 10);
    chk("held_busy", busys, 30);
    chk("held_gaps", gaps_bad, 0);
    repeat (2) @(negedge sys_clk);

    // Randomized traffic on words 32..47 against a byte-lane reference
    have_load = 1'b0; last_load = 32'h0;
    for (int n = 0; n < 300; n++) begin
      logic        rwe;
      logic [3:0]  rbe;
      logic [3:0]  w;
      logic [31:0] rwd, a, expv;
      int          elat, enstb;
      rwe = 1'($urandom_range(0, 1));
      rbe = 4'($urandom_range(0, 15));
      w   = 4'($urandom_range(0, 15));
      rwd = $urandom;
      a   = {24'h0, 2'b10, w, 2'($urandom_range(0, 3))};
      do_req(rwe, rbe, a, rwd, lat, rdata, nstb, wcyc, wdat, waddr, raddr, err);
      if (!rwe) begin
        elat = 3; enstb = 1;
        chk($sformatf("rnd%0d_load", n), rdata, ref_mem[w]);
        have_load = 1'b1; last_load = ref_mem[w];
      end else begin
        expv = ref_mem[w];
        for (int b = 0; b < 4; b++) if (rbe[b]) expv[8*b +: 8] = rwd[8*b +: 8];
        ref_mem[w] = expv;
        if (rbe == 4'h0)      begin elat = 1; enstb = 0; end
        else if (rbe == 4'hF) begin elat = 2; enstb = 1; end
        else                  begin elat = 4; enstb = 2; end
        if (have_load) chk($sformatf("rnd%0d_hold", n), rdata, last_load);
        if (enstb != 0) chk($sformatf("rnd%0d_wdat", n), wdat, expv);
      end
      chk($sformatf("rnd%0d_lat", n), lat, elat);
      chk($sformatf("rnd%0d_nstb", n), nstb, enstb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ram_dport_rmw.md
Name: ram_dport_rmw

Overview:
- Data-side access controller sitting directly upstream of RAM port 2 (ram2_*) in the memory commutator.
- Accepts CPU loads and byte/halfword/word stores on a single-request handshake.
- RAM port 2 only writes whole 32-bit words, so partial stores are converted into a read-modify-write sequence.
- Returns load data and a one-cycle acknowledge to the CPU.

Parameters:
- DEPTH, 513, number of 32-bit words in the RAM; used for word-address range.
- AW, 16, width of RAM word address (ram2_addr_o).

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- cpu_req_i  in  1  request strobe; sampled only in IDLE.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_be_i  in  4  byte enables for stores; lane i = bits [8i+7:8i].
- cpu_addr_i  in  32  byte address; bits [1:0] ignored.
- cpu_wdata_i  in  32  store data.
- cpu_ack_o  out  1  one-cycle completion pulse.
- cpu_rdata_o  out  32  load data; valid while cpu_ack_o=1 and held until next load completes.
- cpu_busy_o  out  1  high in every state except IDLE.
- cpu_err_o  out  1  range-error pulse, coincident with ack; only with the optional feature, else tied 0.
- ram2_stb_o  out  1  RAM port 2 strobe.
- ram2_we_o  out  1  RAM port 2 write enable.
- ram2_addr_o  out  AW  RAM word address = cpu_addr_i[AW+1:2].
- ram2_data_o  out  32  RAM write data.
- ram2_data_i  in  32  RAM read data; valid on the clock after the read strobe cycle.

Behaviour:
- Reset (async, sys_rst_n=0): state IDLE. All outputs 0: cpu_ack_o, cpu_rdata_o, cpu_busy_o, cpu_err_o, ram2_stb_o, ram2_we_o, ram2_addr_o, ram2_data_o. Latched request registers also cleared to 0.
- Reset mid-operation: sequence aborted, no ack issued, RAM strobe drops immediately.
- All ram2_* and cpu_* outputs are driven from registers or the state register only; there is no combinational path from cpu_*_i to any output.
- On acceptance (IDLE and cpu_req_i=1), latch we, be, word address, and wdata. Requests outside IDLE are ignored; the requester must wait for ack.
- States:
  - IDLE: busy=0.
    - Load -> RD.
    - Store with be=4'hF -> WR (merged data = wdata).
    - Store with be=4'h0 -> RESP, no RAM access.
    - Other store -> RD.
  - RD: stb=1, we=0, addr driven. -> RDW.
  - RDW: stb=0; capture ram2_data_i.
    - Load: cpu_rdata_o <= ram2_data_i, -> RESP.
    - Store: merged lane i = be[i] ? wdata lane i : read lane i, -> WR.
  - WR: stb=1, we=1, data=merged. -> RESP.
  - RESP: cpu_ack_o=1 for exactly one cycle. -> IDLE. busy stays 1 during RESP.
- Latency (request accepted at edge N): ack is high in cycle
  - load: N+3
  - full store: N+2
  - partial store: N+4
  - be=0 store: N+1
- Back-to-back: a new request may be presented in the cycle after RESP and is accepted at that edge.
- Only one outstanding access; stb is never asserted in two consecutive cycles except none. RD and WR are each single-cycle strobes.
- Address arithmetic: word address = cpu_addr_i[AW+1:2]. Bits above AW+1 are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: DPORT_RANGE_CHK_EN.
- Defined: at acceptance, if cpu_addr_i[31:2] >= DEPTH, go straight to RESP with no RAM strobe. cpu_ack_o=1 and cpu_err_o=1 in the same cycle. For a load, cpu_rdata_o=0.
- Undefined: no check. The address is truncated to AW bits and the access proceeds. cpu_err_o is constant 0.

Test Plan:
- Reset asserted mid-WR: all outputs 0 asynchronously; after release, busy=0 and no ack ever appears for the aborted request.
- Full store addr 0x10, be=F, data 0xDEADBEEF: ram2 stb/we=1 with addr=4 and data 0xDEADBEEF in N+1; ack in N+2. Following load of 0x10 returns 0xDEADBEEF with ack in N+3.
- Partial store addr 0x10, be=4'b0010, data 0x0000AA00, over stored 0xDEADBEEF: read strobe in N+1, write of 0xDEADAAEF in N+3, ack in N+4.
- Store with be=0: ack in N+1, ram2_stb_o never asserted.
- cpu_req_i held high continuously: exactly one ack per accepted request, busy high between accepts, and no requests accepted while busy.
- With DPORT_RANGE_CHK_EN defined, load of addr 0x804 (word 513): ack=1, err=1, rdata=0, no strobe. Without the macro, the same request is accepted and ram2_addr_o=0x0201.
